// File: rtl/bpf_fetch_unit.sv
// BPF CPU fetch front end: owns the PC, drives the dual-port code memory and
// sequences one filter run per packet (IDLE -> RUN -> DONE).
module bpf_fetch_unit #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_inst_rd_en,
    input  logic                       i_pc_en,
    input  logic [1:0]                 i_pc_sel,
    input  logic [CODE_ADDR_WIDTH-1:0] i_jt,
    input  logic [CODE_ADDR_WIDTH-1:0] i_jf,
    input  logic [31:0]                i_imm,
    input  logic [CODE_ADDR_WIDTH-1:0] i_jmp_correction,
    input  logic                       i_acc,
    input  logic                       i_rej,
    output logic [CODE_ADDR_WIDTH-1:0] o_code_addr,
    output logic                       o_code_rd_en,
    input  logic [63:0]                i_code_data,
    output logic [63:0]                o_instr_out,
    output logic                       o_running,
    output logic                       o_verdict_vld,
    output logic                       o_verdict_acc
);

    localparam int W = CODE_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_pc;
    logic [W-1:0]   w_pc_nxt;
    logic           r_rd_pending;
    logic [63:0]    r_instr_hold;
    logic           r_verdict_acc;
    logic           w_running;
    logic           w_verdict_vld;
    logic           w_code_rd_en;
    logic           w_verdict;
    logic           w_unused_imm;

    // Redirect target; all operands are already W bits so the sum wraps silently.
    function automatic logic [W-1:0] f_redirect(input logic [W-1:0] pc,
                                                input logic [W-1:0] off,
                                                input logic [W-1:0] corr);
        return pc + off - corr;
    endfunction

    assign w_unused_imm = ^i_imm[31:W];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_verdict) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        w_running     = (r_state == ST_RUN);
        w_verdict_vld = (r_state == ST_DONE);
        w_code_rd_en  = w_running & i_inst_rd_en;
        w_verdict     = w_running & (i_acc | i_rej);
    end

    // Next PC: redirects are suppressed in the verdict cycle, PC parks at 0 outside RUN
    always_comb begin
        w_pc_nxt = r_pc;
        case (r_state)
            ST_RUN: begin
                if (w_verdict || !i_pc_en) begin
                    w_pc_nxt = r_pc;
                end else begin
                    case (i_pc_sel)
                        2'b00:   w_pc_nxt = r_pc + {{(W-1){1'b0}}, 1'b1};
                        2'b01:   w_pc_nxt = f_redirect(r_pc, i_jt, i_jmp_correction);
                        2'b10:   w_pc_nxt = f_redirect(r_pc, i_jf, i_jmp_correction);
                        2'b11:   w_pc_nxt = f_redirect(r_pc, i_imm[W-1:0], i_jmp_correction);
                        default: w_pc_nxt = r_pc;
                    endcase
                end
            end
            ST_IDLE: w_pc_nxt = {W{1'b0}};
            ST_DONE: w_pc_nxt = {W{1'b0}};
            default: w_pc_nxt = {W{1'b0}};
        endcase
    end

    // PC, read tracking, instruction hold and verdict registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= {W{1'b0}};
            r_rd_pending  <= 1'b0;
            r_instr_hold  <= 64'd0;
            r_verdict_acc <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            // A read launched in the verdict cycle is dropped.
            r_rd_pending <= w_code_rd_en & ~w_verdict;
            if (r_rd_pending) begin
                r_instr_hold <= i_code_data;
            end else begin
                r_instr_hold <= r_instr_hold;
            end
            if (w_verdict) begin
                r_verdict_acc <= i_acc;
            end else begin
                r_verdict_acc <= r_verdict_acc;
            end
        end
    end

    assign o_code_addr   = r_pc;
    assign o_code_rd_en  = w_code_rd_en;
    assign o_instr_out   = r_rd_pending ? i_code_data : r_instr_hold;
    assign o_running     = w_running;
    assign o_verdict_vld = w_verdict_vld;
    assign o_verdict_acc = r_verdict_acc;

endmodule

// File: tb/tb_bpf_fetch_unit.sv
// Scoreboard bench for bpf_fetch_unit: stimulus queues expected addresses,
// instructions and verdicts; a negedge monitor pops and compares them.
module tb_bpf_fetch_unit;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          inst_rd_en = 1'b0;
    logic          pc_en = 1'b0;
    logic [1:0]    pc_sel = 2'b00;
    logic [W-1:0]  jt = '0;
    logic [W-1:0]  jf = '0;
    logic [31:0]   imm = 32'd0;
    logic [W-1:0]  jcorr = '0;
    logic          acc = 1'b0;
    logic          rej = 1'b0;
    logic [W-1:0]  code_addr;
    logic          code_rd_en;
    logic [63:0]   code_data = 64'd0;
    logic [63:0]   instr_out;
    logic          running;
    logic          verdict_vld;
    logic          verdict_acc;

    logic [63:0]   mem [0:(1<<W)-1];

    logic [W-1:0]  addr_q[$];
    logic [63:0]   instr_q[$];
    logic          vacc_q[$];
    logic [W-1:0]  vaddr_q[$];

    int            n_checks = 0;
    int            n_fail = 0;
    logic          hold_chk = 1'b0;
    logic [63:0]   hold_val = 64'd0;
    logic          mon_prev_rd = 1'b0;

    bpf_fetch_unit #(.CODE_ADDR_WIDTH(W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_inst_rd_en    (inst_rd_en),
        .i_pc_en         (pc_en),
        .i_pc_sel        (pc_sel),
        .i_jt            (jt),
        .i_jf            (jf),
        .i_imm           (imm),
        .i_jmp_correction(jcorr),
        .i_acc           (acc),
        .i_rej           (rej),
        .o_code_addr     (code_addr),
        .o_code_rd_en    (code_rd_en),
        .i_code_data     (code_data),
        .o_instr_out     (instr_out),
        .o_running       (running),
        .o_verdict_vld   (verdict_vld),
        .o_verdict_acc   (verdict_acc)
    );

    always #5 clk = ~clk;

    // Code memory: data valid one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (code_rd_en) code_data <= mem[code_addr];
        else            code_data <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations
    always @(negedge clk) begin
        if (code_rd_en === 1'b1) begin
            if (addr_q.size() == 0) chk("unexpected_rd", 64'(code_addr), 64'hFFFF_FFFF);
            else chk("code_addr", 64'(code_addr), 64'(addr_q.pop_front()));
        end
        if (mon_prev_rd && running === 1'b1) begin
            if (instr_q.size() == 0) chk("unexpected_instr", instr_out, 64'hFFFF_FFFF);
            else chk("instr_out", instr_out, instr_q.pop_front());
        end else if (hold_chk && running === 1'b1) begin
            chk("hold_instr", instr_out, hold_val);
            chk("hold_rd_en", 64'(code_rd_en), 64'd0);
        end
        if (verdict_vld === 1'b1) begin
            if (vacc_q.size() == 0) chk("unexpected_verdict", 64'(verdict_acc), 64'hFFFF_FFFF);
            else begin
                chk("verdict_acc", 64'(verdict_acc), 64'(vacc_q.pop_front()));
                chk("done_addr", 64'(code_addr), 64'(vaddr_q.pop_front()));
            end
        end
        mon_prev_rd = (code_rd_en === 1'b1);
    end

    task automatic drive(input logic s, input logic rd, input logic pe,
                         input logic [1:0] sel, input logic a, input logic r);
        start = s; inst_rd_en = rd; pc_en = pe; pc_sel = sel; acc = a; rej = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < (1 << W); k++) mem[k] = 64'(k);

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_code_addr", 64'(code_addr), 64'd0);
        chk("rst_code_rd_en", 64'(code_rd_en), 64'd0);
        chk("rst_instr_out", instr_out, 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_verdict_vld", 64'(verdict_vld), 64'd0);
        chk("rst_verdict_acc", 64'(verdict_acc), 64'd0);

        // Sequential fetch 0..5, branch 5->8, jump 8->1022, wrap 1022->1
        for (int k = 0; k < 6; k++) begin
            addr_q.push_back(W'(k));
            instr_q.push_back(64'(k));
        end
        addr_q.push_back(W'(8));    instr_q.push_back(64'd8);
        addr_q.push_back(W'(1022)); instr_q.push_back(64'd1022);
        addr_q.push_back(W'(1));    instr_q.push_back(64'hDEAD);

        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("start_running", 64'(running), 64'd1);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("pc_before_branch", 64'(code_addr), 64'd5);
        jt = W'(4); jcorr = W'(1);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        imm = 32'd1014; jcorr = W'(0);
        drive(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        mem[1] = 64'hDEAD;
        imm = 32'h0000_0403;
        drive(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Stall three cycles: last instruction must stay on instr_out
        hold_val = 64'hDEAD;
        hold_chk = 1'b1;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // acc and rej together: accept wins, redirect in that cycle ignored
        jt = W'(4); jcorr = W'(1);
        vacc_q.push_back(1'b1); vaddr_q.push_back(W'(1));
        drive(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        hold_chk = 1'b0;
        chk("verdict_vld_n1", 64'(verdict_vld), 64'd1);
        chk("verdict_acc_n1", 64'(verdict_acc), 64'd1);
        chk("running_n1", 64'(running), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("start_in_done_ignored", 64'(running), 64'd0);
        chk("idle_pc", 64'(code_addr), 64'd0);
        chk("verdict_one_cycle", 64'(verdict_vld), 64'd0);

        // Restart from PC 0, run to PC 7, then reset mid-run
        mem[0] = 64'hA5A5_A5A5_0000_0001;
        for (int k = 0; k < 7; k++) begin
            addr_q.push_back(W'(k));
            instr_q.push_back(mem[k]);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("restart_addr", 64'(code_addr), 64'd0);
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("pc_before_rst", 64'(code_addr), 64'd7);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_running", 64'(running), 64'd0);
        chk("midrst_pc", 64'(code_addr), 64'd0);
        chk("midrst_instr", instr_out, 64'd0);
        chk("midrst_no_verdict", 64'(verdict_vld), 64'd0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Reject run; the read issued in the verdict cycle is discarded
        addr_q.push_back(W'(0));
        vacc_q.push_back(1'b0); vaddr_q.push_back(W'(0));
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("rej_verdict_acc", 64'(verdict_acc), 64'd0);
        chk("discarded_read", instr_out, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("instr_q_drained", 64'(instr_q.size()), 64'd0);
        chk("verdict_q_drained", 64'(vacc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bpf_fetch_unit.md
# bpf_fetch_unit

Program-counter and instruction-fetch front end for the BPF CPU. It owns the PC, issues reads to the dual-port code memory, and presents the 64-bit instruction to the controller's `instr_in`. It consumes the controller's `inst_rd_en`, `PC_en`, `PC_sel`, `jt`, `jf`, `jmp_correction`, `acc` and `rej`. It also sequences one filter run per packet: idle, run, then report the verdict.

## Interface
Parameters:
- `CODE_ADDR_WIDTH`, 10: width of the PC and of the code-memory address.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  packet ready in packet memory. Sampled only in IDLE.
- `inst_rd_en`  in  1  controller requests the instruction at the current PC.
- `PC_en`  in  1  advance or redirect the PC this cycle.
- `PC_sel`  in  2  next-PC select: 00 = PC+1, 01 = taken (jt), 10 = not taken (jf), 11 = jump always (imm).
- `jt`, `jf`  in  `CODE_ADDR_WIDTH`  branch offsets.
- `imm`  in  32  jump-always offset; only bits `[CODE_ADDR_WIDTH-1:0]` are used.
- `jmp_correction`  in  `CODE_ADDR_WIDTH`  pipeline-depth correction, subtracted from every redirect.
- `acc`, `rej`  in  1  program verdict pulses.
- `code_addr`  out  `CODE_ADDR_WIDTH`  code-memory read address; equals the PC.
- `code_rd_en`  out  1  code-memory read strobe.
- `code_data`  in  64  code-memory read data; valid exactly 1 cycle after `code_rd_en`.
- `instr_out`  out  64  instruction presented to the controller's `instr_in`.
- `running`  out  1  high while in RUN.
- `verdict_vld`  out  1  one-cycle pulse when a run finishes.
- `verdict_acc`  out  1  1 = accept, 0 = reject; valid while `verdict_vld` is high.

## Operation
States:
- IDLE
  - PC is held at 0; `code_rd_en` = 0.
  - `start` = 1 moves to RUN.
- RUN
  - `code_rd_en` = `inst_rd_en`.
  - When `PC_en` = 1, PC is updated according to `PC_sel`:
    - 00: PC ← PC+1.
    - 01: PC ← PC + `jt` − `jmp_correction`.
    - 10: PC ← PC + `jf` − `jmp_correction`.
    - 11: PC ← PC + `imm[W-1:0]` − `jmp_correction`.
  - `acc` or `rej` moves to DONE and latches the verdict. If both are high in the same cycle, `acc` wins.
  - In the verdict cycle, any `PC_en` is ignored and the read issued that cycle is discarded.
- DONE
  - `verdict_vld` = 1 for exactly one cycle.
  - PC ← 0; next state is always IDLE.
  - `start` is ignored in DONE and in RUN.

Arithmetic:
- All PC arithmetic is unsigned, modulo 2^`CODE_ADDR_WIDTH`, so wrap-around is silent. PC = 2^W−1 with `PC_sel` 00 gives 0.
- Operands are truncated before the add, never after.

Instruction buffering:
- `rd_pending` is a flag set on the cycle after `code_rd_en`.
- `instr_out` = `rd_pending` ? `code_data` : `instr_hold` (bypass mux).
- `instr_hold` latches `code_data` whenever `rd_pending` = 1. The last fetched instruction therefore stays stable while the controller stalls (`inst_rd_en` = 0).
- A PC redirect (`PC_sel` ≠ 00 with `PC_en`) does not touch `instr_hold`. The controller squashes in-flight instructions itself.

Reset:
- Reset mid-run aborts immediately: state IDLE, PC 0, no verdict pulse.

## Timing
- Reset values: state IDLE, PC 0, `code_addr` 0, `code_rd_en` 0, `instr_hold` 0, `instr_out` 0, `rd_pending` 0, `running` 0, `verdict_vld` 0, `verdict_acc` 0.
- `code_addr` and `code_rd_en` are combinational from the PC register, the state register and `inst_rd_en`.
- `start` at cycle N:
  - `running` = 1 at N+1.
  - The first read (address 0) can issue at N+1.
  - The instruction appears on `instr_out` at N+2.
- `PC_en` at cycle N: the new address appears on `code_addr` at N+1.
- `acc`/`rej` at cycle N: `running` = 0 and `verdict_vld` = 1 at N+1; IDLE at N+2. The earliest next `start` is accepted at N+2.
- Fetch throughput: one instruction per cycle when `inst_rd_en` and `PC_en` are held high.

## Test plan
- Reset, then `start` with `inst_rd_en` = `PC_en` = 1 and memory word k = k → `code_addr` 0,1,2,…; `instr_out` 0,1,2,…, each one cycle after its address.
- PC = 5, `PC_sel` = 01, `jt` = 4, `jmp_correction` = 1 → `code_addr` = 8 next cycle.
- W = 10, PC = 1022, `PC_sel` = 11, `imm` = 0x0000_0403, `jmp_correction` = 0 → `code_addr` = 1 (imm truncated to 3, mod-1024 wrap).
- Stall: `inst_rd_en` = 0 for 3 cycles after fetching word 0xDEAD → `instr_out` holds 0xDEAD throughout; `code_rd_en` = 0.
- `acc` and `rej` both high at cycle N → `verdict_vld` = 1 and `verdict_acc` = 1 at N+1; `start` at N+1 is ignored; `start` at N+2 restarts from PC 0.
- `rst` asserted mid-run at PC 7 → next cycle PC 0, `running` 0, no `verdict_vld` pulse.
